vdma_video_out: RTL
===================

Name: vdma_video_out

Overview:
- Pixel-side output stage of the VDMA read path, directly downstream of the wide-word-to-pixel unpacker.
- Generates raster video timing (hsync, vsync, data-enable) from parameterised counters.
- Drives the unpacker's per-pixel read strobe and frame-alignment pulse, and registers the returned pixels onto the video bus.
- Flags underflow when the unpacker cannot supply a pixel in an active slot.

Parameters:
- DSIZE, 24, pixel width in bits; must equal the unpacker's OSIZE.
- H_ACTIVE, 1920, active pixels per line.
- H_FP, 88, horizontal front porch, in cycles.
- H_SYNC, 44, horizontal sync width, in cycles.
- H_BP, 148, horizontal back porch, in cycles.
- V_ACTIVE, 1080, active lines per frame.
- V_FP, 4, vertical front porch, in lines.
- V_SYNC, 5, vertical sync width, in lines.
- V_BP, 36, vertical back porch, in lines.
- HS_POL, 1, hsync asserted level.
- VS_POL, 1, vsync asserted level.

Ports:
- clock, input, 1, pixel clock.
- rst, input, 1, synchronous active-high reset.
- enable, input, 1, run request from the register block.
- buf_ready, input, 1, frame buffer holds enough data to start a frame.
- pix_rd_en, output, 1, per-pixel read strobe; connects to the unpacker's ord_en.
- pix_align, output, 1, one-cycle frame-alignment pulse; connects to the unpacker's ialign.
- pix_data, input, DSIZE, pixel from the unpacker; valid one cycle after pix_rd_en.
- pix_valid, input, 1, pix_data is genuine in that cycle.
- vid_hs, output, 1, horizontal sync.
- vid_vs, output, 1, vertical sync.
- vid_de, output, 1, active-video enable.
- vid_data, output, DSIZE, pixel output.
- frame_start, output, 1, one-cycle pulse when vcnt=0 and hcnt=0 in RUN.
- underflow, output, 1, sticky underflow flag.

Behaviour:
- Clock and reset: one clock domain, clock; rst is synchronous and active-high.
- Reset values:
  - pix_rd_en, pix_align, vid_de, frame_start, underflow = 0.
  - vid_data = 0.
  - vid_hs = ~HS_POL; vid_vs = ~VS_POL.
  - FSM = IDLE; hcnt = vcnt = 0; delay pipeline cleared.
- Frame geometry:
  - H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP. Line order is sync, back porch, active, front porch.
  - V_TOTAL is built the same way from the V_ parameters, counted in lines.
  - hcnt counts 0..H_TOTAL-1 and wraps to 0. On that wrap, vcnt increments; vcnt wraps to 0 after V_TOTAL-1.
  - Counter width is clog2 of the total.
- Raw timing, computed combinationally from the counters:
  - hs_c = hcnt < H_SYNC.
  - vs_c = vcnt < V_SYNC.
  - act_c = hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) AND vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
- FSM:
  - IDLE: counters held at 0, outputs inactive. Go to WAIT_READY when enable=1.
  - WAIT_READY: outputs inactive. Go to RUN when buf_ready=1; return to IDLE if enable=0.
  - RUN: counters advance every cycle. At the last cycle of a frame (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1):
    - stay in RUN if enable=1 and buf_ready=1;
    - go to WAIT_READY if enable=1 and buf_ready=0;
    - go to IDLE if enable=0.
  - Deasserting enable mid-frame never truncates the frame; the frame completes first.
- Strobes to the unpacker:
  - pix_rd_en = RUN & act_c, combinational. Exactly H_ACTIVE*V_ACTIVE strobes per frame.
  - pix_align and frame_start = RUN & hcnt==0 & vcnt==0. This falls in sync, so it never coincides with pix_rd_en.
- Output alignment:
  - The unpacker returns data 1 cycle after pix_rd_en.
  - hs_c, vs_c and act_c pass through a 2-stage register delay before driving vid_hs, vid_vs and vid_de.
  - When the stage-1 delayed act is set, vid_data <= pix_valid ? pix_data : 0; otherwise vid_data <= 0.
  - Total latency from counter state to video pins is 2 cycles.
- Underflow:
  - Set when the stage-1 delayed act=1 and pix_valid=0.
  - Cleared only by rst or by the FSM entering IDLE.
  - Output continues with black pixels; timing is never stalled.
- Leaving RUN: the delay pipeline drains naturally. The last 2 cycles of the frame carry no active data because they fall in the front porch.

Decomposition:
- Shared package vdma_pkg holds:
  - the timing-parameter set (default 1080p60 constants);
  - the FSM state enum {IDLE, WAIT_READY, RUN};
  - a clog2-based counter-width function.
- One sub-module is natural: vdma_timing_gen.
  - Contains hcnt/vcnt, the run/hold control and the raw hs_c/vs_c/act_c/frame-end decode.
  - Reusable by the write-path capture stage.

Test Plan:
Small parameter set for all scenarios: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=14); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7); frame = 98 cycles.
1. Reset then enable=1, buf_ready=1 -> pix_align pulses once at RUN entry; pix_rd_en high for cycles 4..11 of lines 2..5 (32 total); vid_de is the same pattern delayed 2 cycles; vid_hs asserted 2 cycles per line.
2. Unpacker model returns an incrementing pixel pattern 1..32 -> vid_data shows 1..32 in order, each coinciding with vid_de=1; vid_data=0 elsewhere; underflow stays 0.
3. pix_valid forced 0 on the 5th active pixel -> that vid_data=0, underflow goes to 1 and stays 1; frame timing is unchanged.
4. enable dropped at cycle 40 of a frame -> frame completes all 98 cycles, FSM goes to IDLE, vid_hs/vid_vs inactive, underflow cleared, no further pix_rd_en.
5. buf_ready=0 at frame end with enable=1 -> FSM parks in WAIT_READY; buf_ready=1 three cycles later -> RUN restarts at hcnt=vcnt=0 with a pix_align pulse.
6. rst asserted mid-active-line -> next cycle all outputs at their reset values and FSM in IDLE; after rst release with enable=1, the first frame is bit-identical to scenario 1.

Source files
------------

// File: rtl/vdma_pkg.sv
// Shared definitions for the VDMA pixel path: default 1080p60 timing,
// sequencing states and counter sizing.
package vdma_pkg;

  localparam int DSIZE_DEF    = 24;
  localparam int H_ACTIVE_DEF = 1920;
  localparam int H_FP_DEF     = 88;
  localparam int H_SYNC_DEF   = 44;
  localparam int H_BP_DEF     = 148;
  localparam int V_ACTIVE_DEF = 1080;
  localparam int V_FP_DEF     = 4;
  localparam int V_SYNC_DEF   = 5;
  localparam int V_BP_DEF     = 36;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_READY,
    RUN
  } vdma_state_e;

  function automatic int cnt_w(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vdma_timing_gen.sv
// Raster counters with run/hold control and raw sync/active/frame decode.
// Counters sit at 0 whenever run is low, so a run always starts on a frame boundary.
module vdma_timing_gen
  import vdma_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic clock,
  input  logic rst,
  input  logic run,
  output logic hs_c,
  output logic vs_c,
  output logic act_c,
  output logic frame_first,
  output logic frame_end
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = cnt_w(H_TOTAL);
  localparam int VW      = cnt_w(V_TOTAL);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          h_last, v_last;
  int            h_i, v_i;

  always_comb begin
    h_i         = int'(hcnt_q);
    v_i         = int'(vcnt_q);
    h_last      = (h_i == H_TOTAL - 1);
    v_last      = (v_i == V_TOTAL - 1);
    hs_c        = (h_i < H_SYNC);
    vs_c        = (v_i < V_SYNC);
    act_c       = (h_i >= H_SYNC + H_BP) && (h_i < H_SYNC + H_BP + H_ACTIVE) &&
                  (v_i >= V_SYNC + V_BP) && (v_i < V_SYNC + V_BP + V_ACTIVE);
    frame_first = (h_i == 0) && (v_i == 0);
    frame_end   = h_last && v_last;

    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (!run) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (h_last) begin
      hcnt_d = '0;
      vcnt_d = v_last ? '0 : vcnt_q + VW'(1);
    end else begin
      hcnt_d = hcnt_q + HW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

endmodule

// File: rtl/vdma_video_out.sv
// Pixel-side VDMA output: sequences frames, strobes the unpacker and
// registers returned pixels onto a 2-cycle-aligned video bus.
module vdma_video_out
  import vdma_pkg::*;
#(
  parameter int DSIZE    = DSIZE_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             enable,
  input  logic             buf_ready,
  output logic             pix_rd_en,
  output logic             pix_align,
  input  logic [DSIZE-1:0] pix_data,
  input  logic             pix_valid,
  output logic             vid_hs,
  output logic             vid_vs,
  output logic             vid_de,
  output logic [DSIZE-1:0] vid_data,
  output logic             frame_start,
  output logic             underflow
);

  vdma_state_e      state_q, state_d;
  logic             run, hs_c, vs_c, act_c, frame_first, frame_end;
  logic             hs_p1_q, vs_p1_q, vld_p1_q, hs_p1_d, vs_p1_d, vld_p1_d;
  logic             hs_p2_q, vs_p2_q, vld_p2_q, hs_p2_d, vs_p2_d, vld_p2_d;
  logic [DSIZE-1:0] data_p2_q, data_p2_d;
  logic             underflow_q, underflow_d;

  function automatic logic [DSIZE-1:0] blank_pix(input logic vld, input logic valid,
                                                 input logic [DSIZE-1:0] pix);
    return (vld && valid) ? pix : '0;
  endfunction

  assign run = (state_q == RUN);

  vdma_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clock      (clock),
    .rst        (rst),
    .run        (run),
    .hs_c       (hs_c),
    .vs_c       (vs_c),
    .act_c      (act_c),
    .frame_first(frame_first),
    .frame_end  (frame_end)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (enable) state_d = WAIT_READY;
      WAIT_READY: begin
        if (!enable)        state_d = IDLE;
        else if (buf_ready) state_d = RUN;
      end
      RUN: begin
        // Frame always completes; the decision is taken on its last cycle only.
        if (frame_end) begin
          if (!enable)         state_d = IDLE;
          else if (!buf_ready) state_d = WAIT_READY;
        end
      end
      default:    state_d = IDLE;
    endcase

    // p0 -> p1: raw timing gated by RUN; pixel requested this cycle
    hs_p1_d  = run & hs_c;
    vs_p1_d  = run & vs_c;
    vld_p1_d = run & act_c;

    // p1 -> p2: pixel from the unpacker arrives alongside vld_p1
    hs_p2_d   = hs_p1_q;
    vs_p2_d   = vs_p1_q;
    vld_p2_d  = vld_p1_q;
    data_p2_d = blank_pix(vld_p1_q, pix_valid, pix_data);

    underflow_d = underflow_q | (vld_p1_q & ~pix_valid);
    if (state_d == IDLE) underflow_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= IDLE;
      hs_p1_q     <= 1'b0;
      vs_p1_q     <= 1'b0;
      vld_p1_q    <= 1'b0;
      hs_p2_q     <= 1'b0;
      vs_p2_q     <= 1'b0;
      vld_p2_q    <= 1'b0;
      data_p2_q   <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hs_p1_q     <= hs_p1_d;
      vs_p1_q     <= vs_p1_d;
      vld_p1_q    <= vld_p1_d;
      hs_p2_q     <= hs_p2_d;
      vs_p2_q     <= vs_p2_d;
      vld_p2_q    <= vld_p2_d;
      data_p2_q   <= data_p2_d;
      underflow_q <= underflow_d;
    end
  end

  assign pix_rd_en   = run & act_c;
  assign pix_align   = run & frame_first;
  assign frame_start = run & frame_first;
  assign vid_hs      = HS_POL ? hs_p2_q : ~hs_p2_q;
  assign vid_vs      = VS_POL ? vs_p2_q : ~vs_p2_q;
  assign vid_de      = vld_p2_q;
  assign vid_data    = data_p2_q;
  assign underflow   = underflow_q;

endmodule
